// File: rtl/mpf_vtp_svc_mmio_rsp_merge_if.sv
// Host-bound MMIO read response merge bus: VTP FIFO head, AFU strobe, host stream.
// Latency: none (signal bundle only).
// Backpressure: host_rsp_ready toward the merge; afu_rsp_almost_full toward the AFU.
interface mpf_vtp_svc_mmio_rsp_merge_if #(
  parameter int TID_W = 9
);
  logic             vtp_rsp_valid;
  logic [TID_W-1:0] vtp_rsp_tid;
  logic [63:0]      vtp_rsp_data;
  logic             vtp_rsp_deq;

  logic             afu_rsp_valid;
  logic [TID_W-1:0] afu_rsp_tid;
  logic [63:0]      afu_rsp_data;
  logic             afu_rsp_almost_full;

  logic             host_rsp_valid;
  logic [TID_W-1:0] host_rsp_tid;
  logic [63:0]      host_rsp_data;
  logic             host_rsp_ready;

  // Merge block side
  modport slave (
    input  vtp_rsp_valid, vtp_rsp_tid, vtp_rsp_data,
    output vtp_rsp_deq,
    input  afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
    output afu_rsp_almost_full,
    output host_rsp_valid, host_rsp_tid, host_rsp_data,
    input  host_rsp_ready
  );

  // Environment side (VTP wrapper, AFU, host sink)
  modport master (
    output vtp_rsp_valid, vtp_rsp_tid, vtp_rsp_data,
    input  vtp_rsp_deq,
    output afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
    input  afu_rsp_almost_full,
    input  host_rsp_valid, host_rsp_tid, host_rsp_data,
    output host_rsp_ready
  );
endinterface

// File: rtl/mpf_vtp_svc_mmio_rsp_merge.sv
// Merges VTP CSR read responses and FIFO-buffered AFU MMIO read responses into one host stream, round-robin.
// Latency: VTP 1 cycle, AFU 2 cycles (FIFO stage + output slot); sustains 1 response per cycle.
// Backpressure: host_rsp_ready stalls the output slot; AFU input cannot stall, so almost_full/overflow guard it.
// Optional per-source grant counters: define MPF_VTP_MMIO_RSP_STATS_EN.
module mpf_vtp_svc_mmio_rsp_merge #(
  parameter int MMIO64_TID_WIDTH = 9,
  parameter int AFU_FIFO_DEPTH   = 16,
  parameter int AFU_ALMOST_FULL  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  mpf_vtp_svc_mmio_rsp_merge_if.slave    io,
  output logic                           afu_fifo_overflow,
  output logic [31:0]                    stat_vtp_cnt,
  output logic [31:0]                    stat_afu_cnt
);

  localparam int AW = $clog2(AFU_FIFO_DEPTH);
  typedef logic [AW:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(AFU_FIFO_DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AFU_ALMOST_FULL);

  logic [MMIO64_TID_WIDTH-1:0] fifo_tid  [AFU_FIFO_DEPTH];
  logic [63:0]                 fifo_data [AFU_FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  cnt_t                        fifo_cnt, fifo_cnt_nxt;
  logic                        fifo_empty, fifo_full, fifo_enq, fifo_deq;
  logic                        afu_af_q, ovf_q;

  logic                        host_vld_q;
  logic [MMIO64_TID_WIDTH-1:0] host_tid_q;
  logic [63:0]                 host_data_q;

  // 1 = AFU won the last grant, so VTP wins the next tie
  logic                        rr_last_afu;
  logic                        slot_free, grant_vtp, grant_afu;

  // Arbitration and FIFO control; a dequeue in the same cycle makes room for a full-FIFO enqueue
  always_comb begin
    fifo_empty   = (fifo_cnt == '0);
    fifo_full    = (fifo_cnt == DEPTH_C);
    slot_free    = !host_vld_q || io.host_rsp_ready;
    grant_vtp    = slot_free && io.vtp_rsp_valid && (fifo_empty || rr_last_afu);
    grant_afu    = slot_free && !fifo_empty && (!io.vtp_rsp_valid || !rr_last_afu);
    fifo_deq     = grant_afu;
    fifo_enq     = io.afu_rsp_valid && (!fifo_full || fifo_deq);
    fifo_cnt_nxt = fifo_cnt + cnt_t'(fifo_enq) - cnt_t'(fifo_deq);
  end

  // AFU FIFO storage; contents are invalidated by the pointers on reset
  always_ff @(posedge clk) begin
    if (fifo_enq) begin
      fifo_tid[wr_ptr]  <= io.afu_rsp_tid;
      fifo_data[wr_ptr] <= io.afu_rsp_data;
    end
  end

  // AFU FIFO pointers, occupancy, almost-full and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      afu_af_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_enq) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_deq) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt_nxt;
      afu_af_q <= ((DEPTH_C - fifo_cnt_nxt) <= AF_C);
      if (io.afu_rsp_valid && !fifo_enq) ovf_q <= 1'b1;
    end
  end

  // Output slot load and round-robin pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      host_vld_q  <= 1'b0;
      host_tid_q  <= '0;
      host_data_q <= '0;
      rr_last_afu <= 1'b1;
    end else begin
      if (slot_free) host_vld_q <= grant_vtp || grant_afu;
      if (grant_vtp) begin
        host_tid_q  <= io.vtp_rsp_tid;
        host_data_q <= io.vtp_rsp_data;
        rr_last_afu <= 1'b0;
      end else if (grant_afu) begin
        host_tid_q  <= fifo_tid[rd_ptr];
        host_data_q <= fifo_data[rd_ptr];
        rr_last_afu <= 1'b1;
      end
    end
  end

  assign io.vtp_rsp_deq         = grant_vtp;
  assign io.afu_rsp_almost_full = afu_af_q;
  assign io.host_rsp_valid      = host_vld_q;
  assign io.host_rsp_tid        = host_tid_q;
  assign io.host_rsp_data       = host_data_q;
  assign afu_fifo_overflow      = ovf_q;

`ifdef MPF_VTP_MMIO_RSP_STATS_EN
  // Saturating per-source grant counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_vtp_cnt <= '0;
      stat_afu_cnt <= '0;
    end else begin
      if (grant_vtp && (stat_vtp_cnt != 32'hFFFF_FFFF)) stat_vtp_cnt <= stat_vtp_cnt + 32'd1;
      if (grant_afu && (stat_afu_cnt != 32'hFFFF_FFFF)) stat_afu_cnt <= stat_afu_cnt + 32'd1;
    end
  end
`else
  assign stat_vtp_cnt = '0;
  assign stat_afu_cnt = '0;
`endif

endmodule

// File: tb/tb_mpf_vtp_svc_mmio_rsp_merge.sv
// Scoreboard bench for the MMIO read response merge: per-source expected queues, order/latency/stall/overflow/stats.
// Latency: n/a (testbench).
// Backpressure: drives host_rsp_ready low in the stall and overflow scenarios.
module tb_mpf_vtp_svc_mmio_rsp_merge;
  localparam int TW = 9;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic [63:0]   data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ovf;
  logic [31:0] stv, sta;

  always #5 clk = ~clk;

  mpf_vtp_svc_mmio_rsp_merge_if #(.TID_W(TW)) bus ();

  mpf_vtp_svc_mmio_rsp_merge #(
    .MMIO64_TID_WIDTH(TW),
    .AFU_FIFO_DEPTH(16),
    .AFU_ALMOST_FULL(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus),
    .afu_fifo_overflow(ovf),
    .stat_vtp_cnt(stv),
    .stat_afu_cnt(sta)
  );

  rsp_t          vtp_src[$];
  rsp_t          exp_vtp[$];
  rsp_t          exp_afu[$];
  int            out_cyc[$];
  logic [TW-1:0] out_tids[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc_n = 0;
  int            out_cnt = 0;
  bit            deq_seen, out_seen;
  logic [TW-1:0] out_tid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_vtp();
    bus.vtp_rsp_valid = (vtp_src.size() > 0);
    if (vtp_src.size() > 0) begin
      bus.vtp_rsp_tid  = vtp_src[0].tid;
      bus.vtp_rsp_data = vtp_src[0].data;
    end else begin
      bus.vtp_rsp_tid  = '0;
      bus.vtp_rsp_data = '0;
    end
  endtask

  task automatic vtp_push(input logic [TW-1:0] tid, input logic [63:0] data);
    rsp_t r;
    r.tid  = tid;
    r.data = data;
    vtp_src.push_back(r);
    exp_vtp.push_back(r);
    drive_vtp();
  endtask

  // One-cycle AFU strobe; acc says whether the response is expected to survive
  task automatic afu_pulse(input logic [TW-1:0] tid, input logic [63:0] data, input bit acc);
    rsp_t r;
    r.tid  = tid;
    r.data = data;
    bus.afu_rsp_valid = 1'b1;
    bus.afu_rsp_tid   = tid;
    bus.afu_rsp_data  = data;
    if (acc) exp_afu.push_back(r);
  endtask

  // Observe mid-cycle, then advance one clock and update inputs 1 time unit after the edge
  task automatic step();
    rsp_t obs;
    @(negedge clk);
    deq_seen = bus.vtp_rsp_deq;
    out_seen = bus.host_rsp_valid && bus.host_rsp_ready;
    out_tid  = bus.host_rsp_tid;
    if (deq_seen)
      chk("deq_legal", 64'(bus.vtp_rsp_valid && (!bus.host_rsp_valid || bus.host_rsp_ready)), 64'd1);
    if (out_seen) begin
      obs.tid  = bus.host_rsp_tid;
      obs.data = bus.host_rsp_data;
      out_cnt++;
      out_cyc.push_back(cyc_n);
      out_tids.push_back(obs.tid);
      if (exp_vtp.size() > 0 && exp_vtp[0].tid == obs.tid) begin
        chk("out_vtp_data", obs.data, exp_vtp[0].data);
        void'(exp_vtp.pop_front());
      end else if (exp_afu.size() > 0) begin
        chk("out_afu_tid", 64'(obs.tid), 64'(exp_afu[0].tid));
        chk("out_afu_data", obs.data, exp_afu[0].data);
        void'(exp_afu.pop_front());
      end else begin
        chk("out_unexpected", 64'(obs.tid), 64'h1_0000);
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
    if (deq_seen && vtp_src.size() > 0) void'(vtp_src.pop_front());
    drive_vtp();
    bus.afu_rsp_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_vtp.size() > 0 || exp_afu.size() > 0) && n < max) begin
      step();
      n++;
    end
    if (exp_vtp.size() > 0 || exp_afu.size() > 0)
      chk("drain_timeout", 64'(exp_vtp.size() + exp_afu.size()), 64'd0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vtp_src.delete();
    exp_vtp.delete();
    exp_afu.delete();
    drive_vtp();
    bus.afu_rsp_valid  = 1'b0;
    bus.afu_rsp_tid    = '0;
    bus.afu_rsp_data   = '0;
    bus.host_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [TW-1:0] exp_ord [6];
    logic [31:0] exp_sv, exp_sa;

    do_reset();
    chk("rst_host_vld", 64'(bus.host_rsp_valid), 64'd0);
    chk("rst_host_tid", 64'(bus.host_rsp_tid), 64'd0);
    chk("rst_host_data", bus.host_rsp_data, 64'd0);
    chk("rst_af", 64'(bus.afu_rsp_almost_full), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_deq", 64'(bus.vtp_rsp_deq), 64'd0);
    chk("rst_stat_vtp", 64'(stv), 64'd0);
    chk("rst_stat_afu", 64'(sta), 64'd0);

    // VTP only: dequeue in cycle 0, output in cycle 1
    vtp_push(9'h05, 64'hDEAD_BEEF);
    step();
    chk("t1_deq_c0", 64'(deq_seen), 64'd1);
    chk("t1_out_c0", 64'(out_seen), 64'd0);
    step();
    chk("t1_out_c1", 64'(out_seen), 64'd1);
    chk("t1_tid", 64'(out_tid), 64'h05);
    drain(10);

    // AFU only: output in cycle 2
    afu_pulse(9'h1A, 64'h1234, 1'b1);
    step();
    chk("t2_out_c0", 64'(out_seen), 64'd0);
    step();
    chk("t2_out_c1", 64'(out_seen), 64'd0);
    step();
    chk("t2_out_c2", 64'(out_seen), 64'd1);
    chk("t2_tid", 64'(out_tid), 64'h1A);
    drain(10);

    // Contention: round-robin interleave at full throughput
    out_tids.delete();
    out_cyc.delete();
    for (int i = 1; i <= 3; i++) vtp_push(TW'(i), 64'h100 + 64'(i));
    for (int i = 0; i < 3; i++) begin
      afu_pulse(TW'(11 + i), 64'h200 + 64'(i), 1'b1);
      step();
    end
    drain(20);
    exp_ord = '{9'd1, 9'd11, 9'd2, 9'd12, 9'd3, 9'd13};
    chk("t3_count", 64'(out_tids.size()), 64'd6);
    if (out_tids.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", 64'(out_tids[i]), 64'(exp_ord[i]));
      chk("t3_throughput", 64'(out_cyc[5] - out_cyc[0]), 64'd5);
    end

    // Stall: output held, no VTP dequeue, nothing lost afterwards
    for (int i = 0; i < 3; i++) vtp_push(TW'(9'h21 + i), 64'h300 + 64'(i));
    afu_pulse(9'h31, 64'h400, 1'b1);
    step();
    afu_pulse(9'h32, 64'h401, 1'b1);
    step();
    bus.host_rsp_ready = 1'b0;
    n0 = out_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_deq", 64'(deq_seen), 64'd0);
      chk("t4_vld", 64'(bus.host_rsp_valid), 64'd1);
      chk("t4_hold", 64'((exp_vtp.size() > 0 && bus.host_rsp_tid == exp_vtp[0].tid) ||
                         (exp_afu.size() > 0 && bus.host_rsp_tid == exp_afu[0].tid)), 64'd1);
    end
    chk("t4_no_out", 64'(out_cnt - n0), 64'd0);
    bus.host_rsp_ready = 1'b1;
    drain(30);

    // Overflow: 20 strobes into a stalled sink; 1 in slot + 16 in FIFO survive
    bus.host_rsp_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      afu_pulse(TW'(9'h40 + k), 64'hA000 + 64'(k), k < 17);
      step();
      if (k == 11) chk("t5_af_11", 64'(bus.afu_rsp_almost_full), 64'd0);
      if (k == 12) chk("t5_af_12", 64'(bus.afu_rsp_almost_full), 64'd1);
      if (k == 16) chk("t5_ovf_16", 64'(ovf), 64'd0);
      if (k == 17) chk("t5_ovf_17", 64'(ovf), 64'd1);
    end
    bus.host_rsp_ready = 1'b1;
    n0 = out_cnt;
    drain(60);
    chk("t5_out_cnt", 64'(out_cnt - n0), 64'd17);
    chk("t5_ovf_sticky", 64'(ovf), 64'd1);
    chk("t5_af_drained", 64'(bus.afu_rsp_almost_full), 64'd0);

    // Reset mid-operation discards buffered and held responses
    bus.host_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      afu_pulse(TW'(9'h50 + i), 64'hB000 + 64'(i), 1'b1);
      step();
    end
    do_reset();
    chk("rst2_vld", 64'(bus.host_rsp_valid), 64'd0);
    chk("rst2_ovf", 64'(ovf), 64'd0);
    n0 = out_cnt;
    repeat (5) step();
    chk("rst2_discard", 64'(out_cnt - n0), 64'd0);

    // Stats: 7 VTP and 9 AFU responses
    do_reset();
    for (int i = 0; i < 7; i++) vtp_push(TW'(9'h60 + i), 64'hC000 + 64'(i));
    for (int i = 0; i < 9; i++) begin
      afu_pulse(TW'(9'h70 + i), 64'hD000 + 64'(i), 1'b1);
      step();
    end
    drain(40);
`ifdef MPF_VTP_MMIO_RSP_STATS_EN
    exp_sv = 32'd7;
    exp_sa = 32'd9;
`else
    exp_sv = 32'd0;
    exp_sa = 32'd0;
`endif
    chk("t6_stat_vtp", 64'(stv), 64'(exp_sv));
    chk("t6_stat_afu", 64'(sta), 64'(exp_sa));
    do_reset();
    chk("t6_rst_vtp", 64'(stv), 64'd0);
    chk("t6_rst_afu", 64'(sta), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
